// File: rtl/result_demux.sv
// -----------------------------------------------------------------------------
// result_demux
//
// Result-distribution block for the multicycle, microprogrammed RISC-V
// datapath. It is the write-side counterpart of the 2:1 operand mux. The
// single signed result bus is routed into one of NUM_DEST holding registers
// (A, B, ALUOut, MDR, ...), selected by a microcode field.
//
// Each holding register has a valid flag and a consume strobe. A word that
// has not been consumed is never overwritten. Instead in_ready drops, and the
// microsequencer stalls until the reading side consumes the word.
//
// Parameters
//   NUM_DEST  number of destination holding registers (2..8)
//   WIDTH     data width in bits, signed
//   SEL_W     select width, $clog2(NUM_DEST) with a minimum of 1
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous reset, active high
//   in_data       signed result word
//   in_sel        destination index from microcode
//   in_valid      producer has a word this cycle
//   in_ready      word accepted this cycle (combinational)
//   dest_data     registered holding-register contents, signed
//   dest_valid    per-destination "holds unconsumed word"
//   dest_consume  per-destination consume strobe from the reading side
//   sel_err       sticky out-of-range select flag (RESULT_DEMUX_ERR_EN only)
//
// Build option
//   RESULT_DEMUX_ERR_EN  When defined, the sel_err port and its sticky
//                        register are present. When undefined, out-of-range
//                        words are dropped silently.
// -----------------------------------------------------------------------------
module result_demux #(
  parameter int NUM_DEST = 4,
  parameter int WIDTH    = 32,
  parameter int SEL_W    = (NUM_DEST > 2) ? $clog2(NUM_DEST) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [WIDTH-1:0] dest_data [NUM_DEST],
  output logic [NUM_DEST-1:0]     dest_valid,
  input  logic [NUM_DEST-1:0]     dest_consume
`ifdef RESULT_DEMUX_ERR_EN
  ,
  output logic                    sel_err
`endif
);

  // The select is compared one bit wider than its own width. An index equal
  // to NUM_DEST is then representable, and the range compare is a real
  // compare even when NUM_DEST is a power of two.
  localparam logic [SEL_W:0] NUM_DEST_EXT = (SEL_W+1)'(NUM_DEST);

  logic [SEL_W:0]          sel_ext;
  logic                    sel_in_range;
  logic [NUM_DEST-1:0]     sel_hit;
  logic [NUM_DEST-1:0]     dest_free;
  logic                    transfer;
  logic [NUM_DEST-1:0]     wr_en;

  logic [NUM_DEST-1:0]     valid_q, valid_d;
  logic signed [WIDTH-1:0] data_q [NUM_DEST];
  logic signed [WIDTH-1:0] data_d [NUM_DEST];

  assign sel_ext      = {1'b0, in_sel};
  assign sel_in_range = (sel_ext < NUM_DEST_EXT);

  // One-hot decode of the select. An out-of-range select decodes to all zeros,
  // so no per-destination array is ever indexed past its end.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // logic, so no path leaves it unassigned and no latch is inferred.
    sel_hit = '0;
    for (int i = 0; i < NUM_DEST; i++) begin
      sel_hit[i] = (sel_ext == (SEL_W+1)'(i));
    end
  end

  // A destination can take a word if it is empty, or if it is being consumed
  // on this same edge. The second case gives zero-bubble hand-over.
  assign dest_free = ~valid_q | dest_consume;

  // An out-of-range select is always accepted, so that the word can be dropped.
  assign in_ready = !sel_in_range || |(sel_hit & dest_free);
  assign transfer = in_valid && in_ready;
  assign wr_en    = sel_hit & {NUM_DEST{transfer && sel_in_range}};

  // Consume clears valid first. A write to the same destination on the same
  // edge then sets it again, so the write wins. A consume of an empty
  // destination clears a bit that is already 0, so it has no effect.
  assign valid_d = (valid_q & ~dest_consume) | wr_en;

  // Only the selected destination loads. Every other destination keeps its
  // data, and consumed data stays visible with valid low.
  always_comb begin
    for (int i = 0; i < NUM_DEST; i++) begin
      data_d[i] = wr_en[i] ? in_data : data_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only. Every
      // register then samples pre-edge values, whatever the block order.
      valid_q <= '0;
      // NOTE: the holding registers are a small flop array, not a RAM. Reset
      // clears them so that reset reads back defined zeros.
      for (int i = 0; i < NUM_DEST; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign dest_valid = valid_q;
  assign dest_data  = data_q;

`ifdef RESULT_DEMUX_ERR_EN
  // Sticky flag. It is set by any accepted out-of-range word and cleared only
  // by reset.
  logic sel_err_q, sel_err_d;

  assign sel_err_d = sel_err_q | (transfer && !sel_in_range);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`endif

endmodule

// File: tb/tb_result_demux.sv
// -----------------------------------------------------------------------------
// tb_result_demux
//
// Self-checking bench for result_demux.
//   u_dut   NUM_DEST = 4. Directed cases, then randomized traffic checked
//           against a behavioural model of holding slots.
//   u_dut3  NUM_DEST = 3. Out-of-range select behaviour.
// -----------------------------------------------------------------------------
module tb_result_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Four-destination instance
  logic               rst;
  logic signed [31:0] in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] dest_data [4];
  logic [3:0]         dest_valid;
  logic [3:0]         dest_consume;
`ifdef RESULT_DEMUX_ERR_EN
  logic               sel_err;
`endif

  result_demux #(.NUM_DEST(4), .WIDTH(32)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_sel       (in_sel),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .dest_data    (dest_data),
    .dest_valid   (dest_valid),
    .dest_consume (dest_consume)
`ifdef RESULT_DEMUX_ERR_EN
    ,
    .sel_err      (sel_err)
`endif
  );

  // Three-destination instance
  logic               rst3;
  logic signed [31:0] in_data3;
  logic [1:0]         in_sel3;
  logic               in_valid3;
  logic               in_ready3;
  logic signed [31:0] dest_data3 [3];
  logic [2:0]         dest_valid3;
  logic [2:0]         dest_consume3;
`ifdef RESULT_DEMUX_ERR_EN
  logic               sel_err3;
`endif

  result_demux #(.NUM_DEST(3), .WIDTH(32)) u_dut3 (
    .clk          (clk),
    .rst          (rst3),
    .in_data      (in_data3),
    .in_sel       (in_sel3),
    .in_valid     (in_valid3),
    .in_ready     (in_ready3),
    .dest_data    (dest_data3),
    .dest_valid   (dest_valid3),
    .dest_consume (dest_consume3)
`ifdef RESULT_DEMUX_ERR_EN
    ,
    .sel_err      (sel_err3)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: each slot is a word plus an occupied flag.
  logic [31:0] m_data [4];
  bit          m_full [4];

  // One clock of the four-destination DUT:
  //   1. Drive the inputs and check in_ready against the model.
  //   2. Advance the model.
  //   3. After the edge, compare every slot.
  task automatic cycle(input bit r, input bit v, input logic [1:0] s,
                       input logic [31:0] d, input logic [3:0] c);
    bit exp_ready;
    rst = r; in_valid = v; in_sel = s; in_data = d; dest_consume = c;
    #1;
    // A slot takes a word when it is empty, or when it is emptied this edge.
    exp_ready = !m_full[s] || c[s];
    check($sformatf("in_ready sel=%0d", s), {31'b0, in_ready}, {31'b0, exp_ready});
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] = 0;
        m_data[i] = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (c[i]) m_full[i] = 0;
      end
      if (v && exp_ready) begin
        m_full[s] = 1;
        m_data[s] = d;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("valid[%0d]", i), {31'b0, dest_valid[i]}, {31'b0, m_full[i]});
      check($sformatf("data[%0d]", i), dest_data[i], m_data[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0;
      m_full[i] = 0;
    end
    rst3 = 1'b1; in_valid3 = 1'b0; in_sel3 = '0; in_data3 = '0; dest_consume3 = '0;

    // Reset for 2 cycles, then idle with every select probed.
    cycle(1, 0, 0, 0, 4'b0000);
    cycle(1, 0, 0, 0, 4'b0000);
    check("reset valid", {28'b0, dest_valid}, 32'h0);
`ifdef RESULT_DEMUX_ERR_EN
    check("reset sel_err", {31'b0, sel_err}, 32'h0);
`endif
    for (int s = 0; s < 4; s++) cycle(0, 0, 2'(s), 32'hDEAD_BEEF, 4'b0000);

    // Single write of -123 to destination 2.
    cycle(0, 1, 2, 32'hFFFF_FF85, 4'b0000);
    check("single valid", {28'b0, dest_valid}, 32'h4);
    check("single data2", dest_data[2], 32'hFFFF_FF85);

    // Backpressure: the second write to slot 1 stalls until consume.
    cycle(0, 1, 1, 5, 4'b0000);
    cycle(0, 1, 1, 7, 4'b0000);
    check("stall ready", {31'b0, in_ready}, 32'h0);
    check("stall data1", dest_data[1], 32'd5);
    cycle(0, 1, 1, 7, 4'b0010);
    check("handover valid1", {31'b0, dest_valid[1]}, 32'h1);
    check("handover data1", dest_data[1], 32'd7);

    // Simultaneous consumes of 0 and 3 while writing 9 to 3.
    cycle(0, 1, 0, 1, 4'b0000);
    cycle(0, 1, 3, 9, 4'b1001);
    check("simul valid0", {31'b0, dest_valid[0]}, 32'h0);
    check("simul valid3", {31'b0, dest_valid[3]}, 32'h1);
    check("simul data3", dest_data[3], 32'd9);

    // Reset that coincides with a transfer.
    cycle(1, 1, 0, 11, 4'b0000);
    check("rst-xfer valid", {28'b0, dest_valid}, 32'h0);
    check("rst-xfer data0", dest_data[0], 32'h0);

    // Randomized traffic. A sparse consume keeps stalls frequent.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
            2'($urandom_range(0, 3)), $urandom,
            4'($urandom & $urandom));
    end
`ifdef RESULT_DEMUX_ERR_EN
    check("inrange sel_err", {31'b0, sel_err}, 32'h0);
`endif

    // NUM_DEST = 3: a select of 3 is accepted and dropped.
    rst = 1'b0; in_valid = 1'b0; dest_consume = '0;
    @(posedge clk); @(posedge clk); #1;
    rst3 = 1'b0; in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 42;
    #1;
    check("oor ready", {31'b0, in_ready3}, 32'h1);
    @(posedge clk); #1;
    check("oor valid", {29'b0, dest_valid3}, 32'h0);
    for (int i = 0; i < 3; i++) check($sformatf("oor data[%0d]", i), dest_data3[i], 32'h0);
`ifdef RESULT_DEMUX_ERR_EN
    check("oor sel_err", {31'b0, sel_err3}, 32'h1);
`endif
    in_sel3 = 2'd2; in_data3 = -5;
    @(posedge clk); #1;
    check("n3 valid", {29'b0, dest_valid3}, 32'h4);
    check("n3 data2", dest_data3[2], 32'hFFFF_FFFB);
    #1;
    check("n3 full ready", {31'b0, in_ready3}, 32'h0);
    in_sel3 = 2'd3;
    #1;
    check("n3 oor ready", {31'b0, in_ready3}, 32'h1);
    in_valid3 = 1'b0;
    @(posedge clk); #1;
`ifdef RESULT_DEMUX_ERR_EN
    check("sticky sel_err", {31'b0, sel_err3}, 32'h1);
`endif
    rst3 = 1'b1;
    @(posedge clk); #1;
    check("n3 rst valid", {29'b0, dest_valid3}, 32'h0);
`ifdef RESULT_DEMUX_ERR_EN
    check("n3 rst sel_err", {31'b0, sel_err3}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_demux.md
# result_demux

Result-distribution block for the multicycle, microprogrammed RISC-V datapath: the write-side counterpart of the 2:1 operand mux. It takes the single signed 32-bit result bus and routes each accepted word into one of NUM_DEST holding registers (e.g. A, B, ALUOut, MDR), selected by a microcode field. Each holding register has a valid flag and a consume handshake, so the microsequencer stalls instead of overwriting an unconsumed value.

## Interface
Parameters:
- NUM_DEST, 4: number of destination holding registers (2..8).
- WIDTH, 32: data width, signed.
- SEL_W, $clog2(NUM_DEST) (min 1): select width.

Ports:
- clk  input  1  the single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  signed result word.
- in_sel  input  SEL_W  destination index from microcode.
- in_valid  input  1  producer has a word this cycle.
- in_ready  output  1  block accepts the word this cycle (combinational).
- dest_data  output  NUM_DEST x WIDTH  registered holding-register contents, signed.
- dest_valid  output  NUM_DEST  per-destination "holds unconsumed word".
- dest_consume  input  NUM_DEST  per-destination consume strobe from the reading side.
- sel_err  output  1  sticky out-of-range select flag (only with RESULT_DEMUX_ERR_EN).

## Operation
- Transfer occurs when in_valid && in_ready on a rising edge.
- in_ready = (in_sel >= NUM_DEST) || !dest_valid[in_sel] || dest_consume[in_sel]; depends only on current inputs and registered state.
- On transfer with in-range sel: dest_data[in_sel] <= in_data unchanged (no extension or truncation; width exactly WIDTH); dest_valid[in_sel] <= 1.
- dest_consume[i] && dest_valid[i] clears dest_valid[i] unless the same edge writes i (write wins; valid stays 1, data takes new word).
- dest_consume[i] while dest_valid[i] == 0: ignored, no state change.
- Multiple consume bits may be asserted at once; each handled independently.
- Non-selected destinations never change data on a transfer.
- Out-of-range sel (possible only when NUM_DEST is not a power of two): word accepted and dropped; no dest changes; sel_err set if compiled in.
- in_valid low: in_ready still computed, no transfer; in_data/in_sel are don't-care.
- dest_data retains last written value after consume (valid only qualifies it).

## Timing
- Reset (rst high at an edge): dest_valid all 0, dest_data all 0, sel_err 0; any in-flight transfer and consume on that edge are discarded. in_ready after reset = 1 for every sel.
- Write latency: 1 cycle; data and valid visible the cycle after the accepting edge.
- Consume-to-ready: same-cycle (consume with a new write to the same dest completes at one edge, zero bubbles).
- Back-to-back writes to different destinations: one per cycle, no stall.
- Back-to-back writes to the same destination without consume: second write stalls (in_ready 0) until consume asserts.
- Producer must hold in_data/in_sel stable while in_valid && !in_ready.

## Configuration
- RESULT_DEMUX_ERR_EN defined: sel_err port present; set on any transfer with in_sel >= NUM_DEST; cleared only by rst.
- Undefined: sel_err port and its register absent; out-of-range transfers silently dropped, behaviour otherwise identical.

## Test plan
- Reset then idle: rst high 2 cycles -> dest_valid = 0000, all dest_data = 0, in_ready = 1 for sel 0..3, sel_err = 0.
- Single write: in_data = 32'hFFFF_FF85 (-123), sel = 2, valid 1 cycle -> next cycle dest_valid = 0100, dest_data[2] = -123, others 0.
- Stall/backpressure: write 5 to sel 1, then 7 to sel 1 with no consume -> in_ready 0, dest_data[1] stays 5; assert dest_consume[1] -> same edge accepts 7, dest_valid[1] stays 1.
- Simultaneous: consume[0] and consume[3] while writing 9 to sel 3 -> dest_valid[0] = 0, dest_valid[3] = 1, dest_data[3] = 9.
- Out of range (NUM_DEST = 3, ERR_EN defined): sel = 3, data 42 -> in_ready 1, no dest changes, sel_err = 1 until rst.
- Reset mid-transfer: rst and in_valid both high with sel 0, data 11 -> next cycle dest_valid = 0, dest_data[0] = 0.
